// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the sequential-counter library.
//   - DEFAULT_WIDTH : default counter width used by counter tops.
//   - state_e       : control state of the down-counter/timer (IDLE, RUN).
//   - cnt_op_e      : what the JK counter stages do on the next edge.
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Operation applied to the JK stage array on the next clock edge.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,  // J=K=0 on every bit
    OP_DEC  = 2'd1,  // borrow-chain toggles, count - 1
    OP_LOAD = 2'd2   // J=d, K=~d, count <- d
  } cnt_op_e;

endpackage : counter_pkg

// File: rtl/jk_stage.sv
// ---------------------------------------------------------------------------
// jk_stage
//   One JK flip-flop with synchronous, active-high reset.
//   Ports:
//     clk : clock, state updates on posedge
//     rst : synchronous reset, clears the stage, highest priority
//     j,k : 00 hold, 01 reset, 10 set, 11 toggle
//     q   : registered stage output
// ---------------------------------------------------------------------------
module jk_stage (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    unique case ({j, k})
      2'b00:   bit_d = bit_q;
      2'b01:   bit_d = 1'b0;
      2'b10:   bit_d = 1'b1;
      default: bit_d = ~bit_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its inputs from before the edge; blocking here would create races.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q <= 1'b0;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q = bit_q;

endmodule : jk_stage

// File: rtl/down_counter_timer.sv
// ---------------------------------------------------------------------------
// down_counter_timer
//   Programmable down-counter/timer built from JK flip-flop stages. Loads a
//   start value, counts down on enabled cycles and pulses `done` for one
//   cycle at terminal count, then halts (one-shot) or reloads (periodic).
//   Ports:
//     clk         : sole clock, posedge
//     rst         : synchronous active-high reset, highest priority
//     load        : capture load_val into count and reload register
//     load_val    : value captured on load
//     start       : begin counting (only honoured in IDLE with count != 0)
//     en          : count enable; low freezes count and state in RUN
//     auto_reload : 1 periodic, 0 one-shot; sampled at each terminal step
//     q           : current count (JK stage outputs)
//     busy        : registered, high while in RUN
//     done        : registered one-cycle terminal-count pulse
// ---------------------------------------------------------------------------
module down_counter_timer
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  // Control registers
  state_e           state_q,  state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  // Count path: the JK stages hold the count, the FSM picks their operation.
  logic [WIDTH-1:0] cnt_q;
  cnt_op_e          cnt_op;
  logic [WIDTH-1:0] cnt_data;
  logic [WIDTH-1:0] borrow;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;

  // -------------------------------------------------------------------------
  // Borrow chain: bit i flips on a decrement exactly when all lower bits are
  // zero. Bit 0 always flips.
  // -------------------------------------------------------------------------
  assign borrow[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
    assign borrow[i] = ~|cnt_q[i-1:0];
  end

  // -------------------------------------------------------------------------
  // Next-state / next-operation logic
  // -------------------------------------------------------------------------
  // NOTE: every signal written in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    cnt_op   = OP_HOLD;
    cnt_data = '0;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          // Load beats start when both are present.
          cnt_op   = OP_LOAD;
          cnt_data = load_val;
          reload_d = load_val;
        end else if (start && (cnt_q != '0)) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (load) begin
          // Abort: reload the counter and return to IDLE without a pulse.
          cnt_op   = OP_LOAD;
          cnt_data = load_val;
          reload_d = load_val;
          state_d  = IDLE;
        end else if (en) begin
          // Terminal step intercepts q=1 so the count never underflows.
          // q=0 cannot occur in RUN; it is folded into the terminal branch
          // so the chain can never wrap even if it did.
          if (cnt_q <= WIDTH'(1)) begin
            done_d = 1'b1;
            cnt_op = OP_LOAD;
            if (auto_reload) begin
              cnt_data = reload_q;
            end else begin
              cnt_data = '0;
              state_d  = IDLE;
            end
          end else begin
            cnt_op = OP_DEC;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // -------------------------------------------------------------------------
  // JK input drive for the requested operation
  // -------------------------------------------------------------------------
  always_comb begin
    j_d = '0;
    k_d = '0;
    unique case (cnt_op)
      OP_DEC: begin
        j_d = borrow;
        k_d = borrow;
      end
      OP_LOAD: begin
        j_d = cnt_data;
        k_d = ~cnt_data;
      end
      default: begin
        j_d = '0;
        k_d = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Counter stages
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    jk_stage u_stage (
      .clk (clk),
      .rst (rst),
      .j   (j_d[i]),
      .k   (k_d[i]),
      .q   (cnt_q[i])
    );
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign q    = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// ---------------------------------------------------------------------------
// tb_down_counter_timer
//   Self-checking bench for down_counter_timer (WIDTH=4): a table of
//   directed vectors, hand-written multi-cycle sequences and a randomized
//   phase compared against a behavioural model of the timer.
// ---------------------------------------------------------------------------
module tb_down_counter_timer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] q;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int m_cnt  = 0;
  int m_rl   = 0;
  bit m_run  = 1'b0;
  bit m_done = 1'b0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input int eq, input bit eb, input bit ed);
    check({name, "_q"},    32'(q),    32'(eq));
    check({name, "_busy"}, 32'(busy), 32'(eb));
    check({name, "_done"}, 32'(done), 32'(ed));
  endtask

  // Model of one clock edge, written from the timer's rules.
  task automatic model_edge(input bit r, input bit ld, input int lv,
                            input bit st, input bit e, input bit ar);
    if (r) begin
      m_cnt = 0; m_rl = 0; m_run = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (ld) begin
        m_cnt = lv; m_rl = lv; m_run = 0;
      end else if (!m_run) begin
        if (st && m_cnt != 0) m_run = 1;
      end else if (e) begin
        if (m_cnt == 1) begin
          m_done = 1;
          if (ar) m_cnt = m_rl;
          else begin
            m_cnt = 0; m_run = 0;
          end
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input bit r, input bit ld, input int lv,
                      input bit st, input bit e, input bit ar);
    @(negedge clk);
    rst = r; load = ld; load_val = W'(lv); start = st; en = e; auto_reload = ar;
    @(posedge clk);
    model_edge(r, ld, lv, st, e, ar);
    #1;
  endtask

  typedef struct {
    bit    r, ld;
    int    lv;
    bit    st, e, ar;
    int    eq;
    bit    eb, ed;
    string name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; en = 1'b0; auto_reload = 1'b0;

    // ---------------- Table-driven directed vectors ----------------
    //            r ld lv st e ar   q  b  d
    vecs.push_back('{1, 0, 0, 0, 0, 0,  0, 0, 0, "reset"});
    vecs.push_back('{1, 1, 7, 1, 1, 0,  0, 0, 0, "rst_over_load"});
    vecs.push_back('{0, 1, 5, 0, 0, 0,  5, 0, 0, "load5"});
    vecs.push_back('{0, 0, 0, 1, 0, 0,  5, 1, 0, "start"});
    vecs.push_back('{0, 0, 0, 0, 0, 0,  5, 1, 0, "hold_en0"});
    vecs.push_back('{0, 0, 0, 1, 1, 0,  4, 1, 0, "dec4"});
    vecs.push_back('{0, 0, 0, 0, 1, 0,  3, 1, 0, "dec3"});
    vecs.push_back('{0, 0, 0, 0, 1, 0,  2, 1, 0, "dec2"});
    vecs.push_back('{0, 0, 0, 0, 1, 0,  1, 1, 0, "dec1"});
    vecs.push_back('{0, 0, 0, 0, 1, 0,  0, 0, 1, "terminal"});
    vecs.push_back('{0, 0, 0, 0, 1, 0,  0, 0, 0, "done_clears"});
    vecs.push_back('{0, 0, 0, 1, 1, 0,  0, 0, 0, "start_q0"});
    vecs.push_back('{0, 1, 3, 1, 0, 0,  3, 0, 0, "load_wins"});
    vecs.push_back('{0, 0, 0, 0, 1, 0,  3, 0, 0, "idle_no_count"});

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].e, vecs[i].ar);
      check_out(vecs[i].name, vecs[i].eq, vecs[i].eb, vecs[i].ed);
    end

    // ---------------- Periodic, L=3, 10 enabled cycles ----------------
    step(0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    check_out("per_start", 3, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0, 1, 1);
      check_out($sformatf("per_%0d", k), 3 - (k % 3), 1, (k % 3) == 0);
    end

    // ---------------- One-shot L=4 with en toggling ----------------
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      int e_cnt;
      step(0, 0, 0, 0, (i % 2) == 0, 0);
      e_cnt = i / 2 + 1;
      check_out($sformatf("tog_%0d", i), (e_cnt >= 4) ? 0 : 4 - e_cnt, i < 6, i == 6);
    end

    // ---------------- Load abort in RUN at q=2 ----------------
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check_out("abort_pre", 2, 1, 0);
    step(0, 1, 9, 0, 1, 0);
    check_out("abort", 9, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check_out("abort_start", 9, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check_out("abort_dec", 8, 1, 0);

    // ---------------- Reset mid-run at q=2 ----------------
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
    check_out("rst_pre", 2, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    check_out("rst_mid", 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    check_out("rst_start_q0", 0, 0, 0);

    // ---------------- Full borrow chain, L=15 one-shot ----------------
    step(0, 1, 15, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    check_out("l15_start", 15, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      step(0, 0, 0, 0, 1, 0);
      check_out($sformatf("l15_%0d", k), 15 - k, k < 15, k == 15);
    end
    step(0, 0, 0, 0, 1, 0);
    check_out("l15_nowrap", 0, 0, 0);

    // ---------------- Randomized against the model ----------------
    for (int n = 0; n < 2000; n++) begin
      bit r, ld, st, e, ar;
      int lv;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 11) == 0);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 15));
      st = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1) == 1;
      step(r, ld, lv, st, e, ar);
      check_out($sformatf("rnd_%0d", n), m_cnt, m_run, m_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_down_counter_timer

// File: doc/down_counter_timer.md
# down_counter_timer

Programmable down-counter/timer built from JK flip-flop stages. It is the decrementing counterpart of the free-running JK up-counter. It loads a start value, counts down on enabled cycles, and flags terminal count with a one-cycle `done` pulse. It then either halts (one-shot) or reloads (periodic), so it can serve as the interval/timeout generator beside the up-counters in the sequential-circuits library.

## Interface
- `WIDTH`, default 4: counter and load-value width (≥2).
- `clk` in 1: sole clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset; highest priority.
- `load` in 1: capture `load_val` into count and reload register.
- `load_val` in WIDTH: value captured on `load`.
- `start` in 1: begin counting (sampled in IDLE only).
- `en` in 1: count enable; low freezes count and state.
- `auto_reload` in 1: 1 = periodic, 0 = one-shot; sampled at each terminal step.
- `q` out WIDTH: current count, registered.
- `busy` out 1: registered, high while in RUN.
- `done` out 1: registered one-cycle terminal-count pulse.

## Operation
- Reset values (after any posedge with `rst`=1):
  - `q`=0, reload register=0, state IDLE.
  - `busy`=0, `done`=0.
- `done` defaults to 0 every cycle unless set by a terminal step.
- IDLE:
  - `load`=1: `q`←`load_val`, reload←`load_val`; stay IDLE.
  - `load`=0, `start`=1, `q`≠0: go to RUN; `q` unchanged.
  - `start` with `q`=0: ignored; no `done`.
  - `load` and `start` together: load wins, start dropped.
- RUN, priority order:
  1. `load`=1: abort. `q`←`load_val`, reload←`load_val`, go to IDLE, no `done`.
  2. `en`=0: hold everything.
  3. `en`=1, `q`>1: `q`←`q`−1.
  4. `en`=1, `q`=1 (terminal step): `done`←1. If `auto_reload`=1, `q`←reload and stay in RUN. If `auto_reload`=0, `q`←0 and go to IDLE.
- `start` in RUN is ignored.
- Auto-reload: `q` never shows 0 while running. With reload value 1, `done` pulses on every enabled cycle.
- Arithmetic is modulo 2^WIDTH. Underflow is unreachable because the terminal step intercepts `q`=1.
- `busy` = (state==RUN), registered with the state.

## Timing
- One-shot, `start` sampled at edge N, `load_val`=L, `en` held high:
  - `busy`=1 and `q`=L after edge N.
  - `q`=L−k after edge N+k, for k<L.
  - After edge N+L: `q`=0, `done`=1, `busy`=0.
- Periodic: `done` pulses once every L enabled cycles. Each disabled cycle stretches the period by one.
- `load` takes effect on the next edge.
- `rst` mid-run clears `busy`/`done` on that edge, with no pending pulse.

## Structure
- Shared package `counter_pkg`:
  - state typedef: IDLE, RUN.
  - default-width constant.
- Sub-module `jk_stage`: one JK flip-flop with synchronous `rst`.
  - Hold (00), reset (01), set (10), toggle (11).
- Top instantiates WIDTH `jk_stage`s for `q` and drives their inputs as follows:
  - Decrement: bit i gets J=K=1 when counting and all lower bits are 0 (borrow chain). Otherwise J=K=0.
  - Load/reload: J=d, K=~d.
- Reload register and FSM are plain registers in the top.

## Test plan
- Reset, then `load_val`=5 with `load`, then `start`, `en`=1, `auto_reload`=0 → `q` 5,4,3,2,1,0; `done` high one cycle as `q`→0, same cycle `busy`→0.
- `auto_reload`=1, L=3, en=1 for 10 cycles → `q` 3,2,1,3,2,1,…; `done` every 3rd cycle; `busy` stays 1.
- L=4, `en` toggled 1,0,1,0,… → count steps only on enabled cycles; `done` after 4 enabled cycles (8 clocks).
- `load` with `load_val`=9 while RUN at `q`=2 → IDLE, `q`=9, `busy`=0, no `done`; then `start` → counts from 9.
- `rst` asserted at `q`=2 mid-run → next cycle `q`=0, `busy`=0, `done`=0; `start` with `q`=0 afterwards → remains IDLE.
- WIDTH=4, L=15 one-shot → exercises the full borrow chain 15→0; no wrap to 15 after 0.
